// File: rtl/frect_fill_pkg.sv
// frect_fill_pkg: state encoding and signed min/max helpers shared by the fill sequencers.
package frect_fill_pkg;
    localparam int STATEW = 3;
    localparam logic [STATEW-1:0] IDLE  = 3'd0;
    localparam logic [STATEW-1:0] CLIP  = 3'd1;
    localparam logic [STATEW-1:0] CHECK = 3'd2;
    localparam logic [STATEW-1:0] SPAN  = 3'd3;
    localparam logic [STATEW-1:0] DRAW  = 3'd4;

    // Callers widen to 32 bits and cast the result back to their coordinate width.
    function automatic logic signed [31:0] smin(input logic signed [31:0] a, input logic signed [31:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic signed [31:0] smax(input logic signed [31:0] a, input logic signed [31:0] b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/frect_fill_fline.sv
// frect_fill_fline: horizontal span engine, walks x from x0 to x1 (x0<=x1) under oe backpressure.
module frect_fill_fline #(
    parameter int CORDW = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    oe,
    input  logic signed [CORDW-1:0] x0,
    input  logic signed [CORDW-1:0] x1,
    output logic signed [CORDW-1:0] x,
    output logic                    valid,
    output logic                    done
);
    logic signed [CORDW-1:0] xe;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !valid) begin
                x     <= x0;
                xe    <= x1;
                valid <= 1'b1;
            end else if (valid && oe) begin
                if (x == xe) begin
                    valid <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    x <= x + CORDW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/frect_fill.sv
// frect_fill: filled-rectangle sequencer; sorts and clips corners, then draws one span per row.
module frect_fill
    import frect_fill_pkg::*;
#(
    parameter int CORDW  = 16,
    parameter int CANV_W = 320,
    parameter int CANV_H = 240
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    oe,
    input  logic signed [CORDW-1:0] x0,
    input  logic signed [CORDW-1:0] y0,
    input  logic signed [CORDW-1:0] x1,
    input  logic signed [CORDW-1:0] y1,
    output logic signed [CORDW-1:0] x,
    output logic signed [CORDW-1:0] y,
    output logic                    busy,
    output logic                    valid,
    output logic                    done
);
    localparam logic signed [31:0] XMAX = 32'(CANV_W - 1);
    localparam logic signed [31:0] YMAX = 32'(CANV_H - 1);

    logic [STATEW-1:0]       state;
    logic signed [CORDW-1:0] xa, xb, ya, yb;
    logic                    fl_valid, fl_done;

    frect_fill_fline #(.CORDW(CORDW)) fline (
        .clk   (clk),
        .rst   (rst),
        .start (state == SPAN),
        .oe    (state == DRAW && oe),
        .x0    (xa),
        .x1    (xb),
        .x     (x),
        .valid (fl_valid),
        .done  (fl_done)
    );

    assign valid = (state == DRAW) && fl_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    xa    <= CORDW'(smin(32'(x0), 32'(x1)));
                    xb    <= CORDW'(smax(32'(x0), 32'(x1)));
                    ya    <= CORDW'(smin(32'(y0), 32'(y1)));
                    yb    <= CORDW'(smax(32'(y0), 32'(y1)));
                    busy  <= 1'b1;
                    state <= CLIP;
                end
                CLIP: begin
                    xa    <= CORDW'(smax(32'(xa), 32'sd0));
                    xb    <= CORDW'(smin(32'(xb), XMAX));
                    ya    <= CORDW'(smax(32'(ya), 32'sd0));
                    yb    <= CORDW'(smin(32'(yb), YMAX));
                    state <= CHECK;
                end
                // An inverted interval after clipping means nothing lies on the canvas.
                CHECK: if (xa > xb || ya > yb) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end else begin
                    y     <= ya;
                    state <= SPAN;
                end
                SPAN: state <= DRAW;
                DRAW: if (fl_done) begin
                    if (y == yb) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        y     <= y + CORDW'(1);
                        state <= SPAN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frect_fill.sv
// tb_frect_fill: randomized scoreboard bench for frect_fill against a rectangle/clip reference model.
module tb_frect_fill;
    localparam int CW = 16;
    localparam int CANV_W = 320;
    localparam int CANV_H = 240;

    typedef struct { int x; int y; } pix_t;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, oe = 1'b1;
    logic signed [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic signed [CW-1:0] x, y;
    logic busy, valid, done;

    frect_fill #(.CORDW(CW), .CANV_W(CANV_W), .CANV_H(CANV_H)) dut (
        .clk(clk), .rst(rst), .start(start), .oe(oe),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .x(x), .y(y), .busy(busy), .valid(valid), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    pix_t exp_q[$];
    int oe_mode = 0;
    bit active = 0, seen_valid = 0, got_any = 0, held = 0;
    int start_cyc = 0, last_cyc = 0, last_y = 0, hx = 0, hy = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: order the corners, intersect with the canvas, raster-scan what remains.
    task automatic model(input int ax, input int ay, input int bx, input int by);
        int xa, xb, ya, yb;
        xa = (ax < bx) ? ax : bx;
        xb = (ax < bx) ? bx : ax;
        ya = (ay < by) ? ay : by;
        yb = (ay < by) ? by : ay;
        if (xa < 0) xa = 0;
        if (ya < 0) ya = 0;
        if (xb > CANV_W - 1) xb = CANV_W - 1;
        if (yb > CANV_H - 1) yb = CANV_H - 1;
        for (int r = ya; r <= yb; r++)
            for (int c = xa; c <= xb; c++)
                exp_q.push_back('{x: c, y: r});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            oe = (oe_mode == 0) ? 1'b1 : (oe_mode == 1) ? ~oe : 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (held && valid) begin
                check("hold_x", int'(x), hx);
                check("hold_y", int'(y), hy);
            end
            held = valid && !oe;
            hx = int'(x);
            hy = int'(y);
            if (valid && active && !seen_valid) begin
                seen_valid = 1;
                check("first_valid_latency", cyc - start_cyc, 4);
            end
            if (valid && oe) begin
                if (exp_q.size() == 0) begin
                    check("extra_pixel", 1, 0);
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    check("pix_x", int'(x), e.x);
                    check("pix_y", int'(y), e.y);
                    if (got_any && oe_mode == 0)
                        check("pixel_gap", cyc - last_cyc, (int'(y) != last_y) ? 3 : 1);
                    got_any = 1;
                    last_cyc = cyc;
                    last_y = int'(y);
                end
            end
            if (done) begin
                if (!active) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    check("done_cycle", cyc, got_any ? last_cyc + 2 : start_cyc + 3);
                    check("busy_at_done", int'(busy), 0);
                    check("pixels_left", exp_q.size(), 0);
                    active = 0;
                end
            end
        end
    end

    task automatic launch(input int ax, input int ay, input int bx, input int by, input int mode);
        @(posedge clk);
        #1;
        oe_mode = mode;
        x0 = CW'(ax); y0 = CW'(ay); x1 = CW'(bx); y1 = CW'(by);
        start = 1'b1;
        model(ax, ay, bx, by);
        seen_valid = 0;
        got_any = 0;
        start_cyc = cyc;
        active = 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (active && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (active) begin
            check("done_timeout", 0, 1);
            active = 0;
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic fill(input int ax, input int ay, input int bx, input int by, input int mode, input bit poke);
        launch(ax, ay, bx, by, mode);
        if (poke) begin
            repeat (5) @(posedge clk);
            #1;
            x0 = 50; y0 = 50; x1 = 60; y1 = 60;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_done();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_done", int'(done), 0);

        fill(2, 1, 4, 2, 0, 0);
        fill(4, 2, 2, 1, 0, 0);
        fill(-5, -3, 1, 0, 0, 0);
        fill(318, 238, 330, 250, 0, 0);
        fill(400, 10, 410, 20, 0, 0);
        fill(7, 7, 7, 7, 0, 0);
        fill(2, 1, 4, 2, 1, 1);

        // Abort a fill during its second row.
        launch(2, 1, 4, 2, 0);
        for (int n = 0; n < 100 && !(valid && y == 2); n++) @(negedge clk);
        check("reached_row2", int'(valid && y == 2), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        active = 0;
        exp_q.delete();
        @(negedge clk);
        check("rst_valid", int'(valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        repeat (4) @(negedge clk);
        fill(0, 0, 1, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            int ax, ay;
            ax = int'($urandom_range(0, 350)) - 15;
            ay = int'($urandom_range(0, 270)) - 15;
            fill(ax, ay, ax + int'($urandom_range(0, 16)) - 8, ay + int'($urandom_range(0, 16)) - 8,
                 int'($urandom_range(0, 2)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/frect_fill.md
Name: frect_fill

Overview:
Filled-rectangle sequencer for the 2D graphics pipeline.
- Accepts two arbitrary corner points and orders the corners.
- Clips the rectangle to the canvas.
- Issues one horizontal span per row to a fline instance, then emits the (x,y) pixel stream with oe backpressure.
- Sits between the drawing command decoder and the framebuffer write stage.

Parameters:
CORDW, 16, signed coordinate width (bits)
CANV_W, 320, canvas width in pixels; CANV_W-1 must be representable as a positive CORDW signed value
CANV_H, 240, canvas height in pixels; same width constraint

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  begin fill; sampled only in IDLE
oe  input  1  output enable / downstream ready
x0  input  CORDW  signed corner 0 x
y0  input  CORDW  signed corner 0 y
x1  input  CORDW  signed corner 1 x
y1  input  CORDW  signed corner 1 y
x  output  CORDW  signed pixel x
y  output  CORDW  signed pixel y
busy  output  1  fill in progress
valid  output  1  x,y valid this cycle
done  output  1  fill complete, high for one cycle

Behaviour:
- Clocking: single clock domain. Reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, valid=0. x and y are don't-care while valid=0.
- rst is shared with the fline instance.
- rst during any state returns to IDLE. valid=0 from the following cycle. No done pulse is generated.

States and transitions:
- IDLE: done<=0.
  - On start: latch xa=min(x0,x1), xb=max(x0,x1), ya=min(y0,y1), yb=max(y0,y1) using signed compare.
  - Set busy<=1 and go to CLIP.
- CLIP:
  - xa<=max(xa,0), xb<=min(xb,CANV_W-1).
  - ya<=max(ya,0), yb<=min(yb,CANV_H-1).
  - Go to CHECK.
- CHECK:
  - If xa>xb or ya>yb (rectangle fully off-canvas): busy<=0, done<=1, go to IDLE.
  - Otherwise y<=ya and go to SPAN.
- SPAN: drive fline start=1 with fline x0=xa, x1=xb for exactly one cycle, then go to DRAW.
- DRAW:
  - oe is forwarded to fline.
  - valid = (state==DRAW) && fline valid.
  - x comes directly from fline. y is registered and holds for the whole row.
  - On fline done: if y==yb then busy<=0, done<=1, go to IDLE; otherwise y<=y+1 and go to SPAN.

Handshake and timing:
- start while busy is ignored. Inputs x0..y1 are only sampled in the start cycle.
- A pixel is transferred when valid && oe. With oe low, x and y hold and nothing is skipped or duplicated.
- Latency, with start sampled at cycle S: first valid at S+4 (CLIP, CHECK, SPAN, fline enters DRAW).
- Row turnaround: last pixel of a row at cycle N, first pixel of the next row at N+3 (2 bubble cycles).
- Completion: last pixel at N, done=1 and busy=0 at N+2.
- A new start is accepted in the cycle done is high (state is IDLE).
- Empty fill: done at S+3, with valid never asserted.

Arithmetic:
- All comparisons are signed CORDW.
- After clipping, y+1 cannot overflow because y<yb<=CANV_H-1.
- A single-pixel rectangle (x0==x1, y0==y1) produces exactly one pixel.

Decomposition:
- Shared graphics package holds the state encoding localparams (IDLE, CLIP, CHECK, SPAN, DRAW; STATEW=3) and a signed min/max helper function, both reused by other fill blocks.
- One sub-module: fline (CORDW passed through), instantiated as the span engine. Clipping and sorting stay inline.

Test Plan:
- (2,1)-(4,2), oe=1 -> pixels (2,1),(3,1),(4,1),(2,2),(3,2),(4,2) in order; first valid at S+4; 2 bubbles between rows; done at last pixel+2; busy low with done.
- (4,2)-(2,1) swapped corners, oe=1 -> identical pixel sequence and timing to the previous case.
- Clip, with CANV_W=320, CANV_H=240: (-5,-3)-(1,0) -> exactly (0,0),(1,0). Separately, (318,238)-(330,250) -> 4 pixels, x in 318..319 and y in 238..239.
- Off-canvas (400,10)-(410,20) -> valid never high; done=1 at S+3. Single pixel (7,7)-(7,7) -> one pixel (7,7), then done.
- oe pattern 1,0,1,0... on (2,1)-(4,2) -> same 6 pixels with no duplicates or skips; x and y stable while oe=0. start pulsed mid-fill -> ignored, output unchanged.
- rst asserted during the second row -> valid=0 next cycle, busy=0, no done pulse. A subsequent start of (0,0)-(1,0) -> clean 2-pixel fill.
